branch_resolve_bht: RTL

Parametrised branch resolution unit with a bimodal branch history table (BHT). It replaces the single-gate MEM-stage branch decision: it resolves BEQ and BNE branches from the ALU zero flag, drives PCSrc to the fetch-stage PC mux, and flags mispredictions against the prediction it supplied at fetch. It sits between fetch (lookup) and memory stage (resolve/update).

---
 rtl/branch_resolve_bht.sv | 117 +++++++++++
 1 files changed

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_bht
// Description : MEM-stage branch resolution (BEQ/BNE from ALU zero flag) with
//               a bimodal branch history table of saturating counters.
//               Fetch looks up a prediction by if_pc; the MEM stage resolves
//               the branch, drives PCSrc, flags mispredictions and trains
//               the table entry selected by mem_pc.
// Ports       : clk, rst_n (async, active-low)
//               if_pc / if_pred_taken           - fetch-stage lookup
//               mem_valid, mem_branch, mem_bne,
//               zero, mem_pc, mem_pred_taken     - MEM-stage resolve inputs
//               PCSrc, mispredict                - combinational results
//               stats_clr, branch_count,
//               mispredict_count                 - only with BRANCH_STATS_EN
// Config      : define BRANCH_STATS_EN to build the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_bht #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_pred_taken,
    input  logic              mem_valid,
    input  logic              mem_branch,
    input  logic              mem_bne,
    input  logic              zero,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic              mem_pred_taken,
    output logic              PCSrc,
    output logic              mispredict
`ifdef BRANCH_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       branch_count,
    output logic [15:0]       mispredict_count
`endif
);

    localparam int             c_entries  = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] c_cnt_init = {1'b0, {(CNT_W-1){1'b1}}};

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_resolve;
    logic             w_taken;
    logic [CNT_W-1:0] w_cnt [c_entries];

    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_upd_idx = mem_pc[IDX_W+1:2];

    // Upper PC bits alias onto the same entries; byte-offset bits never vary.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{if_pc[ADDR_W-1:IDX_W+2], if_pc[1:0],
                                mem_pc[ADDR_W-1:IDX_W+2], mem_pc[1:0]};

    assign w_resolve  = mem_valid & mem_branch;
    assign w_taken    = zero ^ mem_bne;
    assign PCSrc      = w_resolve & w_taken;
    assign mispredict = w_resolve & (w_taken != mem_pred_taken);

    // Lookup reads the registered value, so a same-cycle update to the same
    // index is seen only on the following cycle.
    assign if_pred_taken = w_cnt[w_if_idx][CNT_W-1];

    generate
        for (genvar g = 0; g < c_entries; g++) begin : g_entry
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= c_cnt_init;
                end else if (w_resolve && (w_upd_idx == IDX_W'(g))) begin
                    if (w_taken) begin
                        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            end

            assign w_cnt[g] = r_cnt;
        end
    endgenerate

`ifdef BRANCH_STATS_EN
    logic [15:0] r_branch_count;
    logic [15:0] r_mispredict_count;

    // Clear wins over a same-cycle increment; both counters stick at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (stats_clr) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_resolve) begin
            if (r_branch_count != 16'hFFFF)
                r_branch_count <= r_branch_count + 16'd1;
            if (mispredict && (r_mispredict_count != 16'hFFFF))
                r_mispredict_count <= r_mispredict_count + 16'd1;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
`endif

endmodule
`default_nettype wire
